// File: rtl/cube_pkg.sv
// cube_pkg: shared definitions for the LED cube front end.
//   NUM_LAYERS  layers per cube (also memory words per frame); shared with the activator
//   COLS        column bits per layer (memory word width)
//   seq_state_t layer_sequencer FSM states
//   addr_width  width helper that never returns zero, so 1-entry ranges still get a bit
package cube_pkg;

  localparam int NUM_LAYERS = 8;
  localparam int COLS       = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    WAIT_ACT,
    LATCH,
    START
  } seq_state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/column_shifter.sv
// column_shifter: parallel-load serialiser for one layer of column bits.
// Each bit takes two cycles: phase 0 presents the bit with sr_clk low,
// phase 1 raises sr_clk with the bit held. The MSB goes out first.
//   clk, rst_n   clock, synchronous active-low reset
//   load         capture data and restart at the MSB
//   data         COLS-bit column word
//   go           advance the serialiser one phase per cycle
//   sr_data      serial bit to the column chain (registered)
//   sr_clk       shift clock to the column chain (registered)
//   shift_done   high during the final phase 1 of the last bit
module column_shifter
  import cube_pkg::*;
#(
  parameter int COLS_P = COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [COLS_P-1:0] data,
  input  logic              go,
  output logic              sr_data,
  output logic              sr_clk,
  output logic              shift_done
);

  localparam int BW = addr_width(COLS_P);
  localparam logic [BW-1:0] LAST_BIT = BW'(COLS_P - 1);

  logic [COLS_P-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              phase;

  // shift_done lets the FSM leave SHIFT on the same edge that drops sr_clk,
  // so no idle cycle is spent after the last bit.
  assign shift_done = go && phase && (bit_cnt == LAST_BIT);

  // The next bit is staged into sr_data on the edge that ends phase 1, so
  // sr_data is already stable when phase 0 of that bit begins. After the
  // last bit, sr_data simply holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      sr_data <= 1'b0;
      sr_clk  <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= '0;
      phase   <= 1'b0;
      sr_data <= data[COLS_P-1];
      sr_clk  <= 1'b0;
    end else if (go) begin
      if (!phase) begin
        sr_clk <= 1'b1;
        phase  <= 1'b1;
      end else begin
        sr_clk  <= 1'b0;
        phase   <= 1'b0;
        shreg   <= {shreg[COLS_P-2:0], 1'b0};
        bit_cnt <= bit_cnt + BW'(1);
        if (bit_cnt != LAST_BIT) begin
          sr_data <= shreg[COLS_P-2];
        end
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: fetches each layer's column word from frame memory, shifts
// it into the column chain, latches it, then hands the layer to the activator.
// Shifting layer N+1 overlaps the activation of layer N.
//   clk, rst_n   clock, synchronous active-low reset
//   enable       run request, honoured in IDLE and at the end of each layer
//   mem_addr     frame memory read address (frame_idx*NUM_LAYERS + layer)
//   mem_rdata    read data, valid one cycle after mem_addr
//   sr_data      serial column bit
//   sr_clk       column shift clock
//   sr_latch     one-cycle storage-register latch pulse
//   act_start    one-cycle start to the activator
//   act_layer    layer being activated, held between starts
//   act_done     one-cycle completion from the activator
//   frame_idx    currently displayed frame
module layer_sequencer
  import cube_pkg::*;
#(
  parameter  int NUM_FRAMES   = 4,
  parameter  int FRAME_REPEAT = 30,
  localparam int AW           = addr_width(NUM_FRAMES * NUM_LAYERS),
  localparam int FW           = addr_width(NUM_FRAMES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  output logic [AW-1:0]   mem_addr,
  input  logic [COLS-1:0] mem_rdata,
  output logic            sr_data,
  output logic            sr_clk,
  output logic            sr_latch,
  output logic            act_start,
  output logic [2:0]      act_layer,
  input  logic            act_done,
  output logic [FW-1:0]   frame_idx
);

  localparam int SW = addr_width(FRAME_REPEAT);
  localparam logic [2:0]    LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam logic [SW-1:0] LAST_SWEEP = SW'(FRAME_REPEAT - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);

  seq_state_t    state;
  logic [2:0]    layer;
  logic [SW-1:0] sweep;
  logic          busy;

  logic [2:0]    layer_nxt;
  logic [SW-1:0] sweep_nxt;
  logic [FW-1:0] frame_nxt;

  logic shift_load;
  logic shift_go;
  logic shift_done;

  function automatic logic [AW-1:0] calc_addr(input logic [FW-1:0] f, input logic [2:0] l);
    return AW'(f) * AW'(NUM_LAYERS) + AW'(l);
  endfunction

  assign shift_load = (state == LOAD);
  assign shift_go   = (state == SHIFT);

  column_shifter #(
    .COLS_P(COLS)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift_load),
    .data      (mem_rdata),
    .go        (shift_go),
    .sr_data   (sr_data),
    .sr_clk    (sr_clk),
    .shift_done(shift_done)
  );

  // Counter values that START commits: layer wraps into sweep, and the last
  // sweep of a frame rolls into the next frame.
  always_comb begin
    layer_nxt = layer + 3'd1;
    sweep_nxt = sweep;
    frame_nxt = frame_idx;
    if (layer == LAST_LAYER) begin
      layer_nxt = 3'd0;
      if (sweep == LAST_SWEEP) begin
        sweep_nxt = '0;
        frame_nxt = (frame_idx == LAST_FRAME) ? '0 : frame_idx + FW'(1);
      end else begin
        sweep_nxt = sweep + SW'(1);
      end
    end
  end

  // Main FSM. mem_addr is loaded on the edge entering FETCH so the memory sees
  // it during FETCH and returns data in LOAD. WAIT_ACT also honours an act_done
  // arriving this cycle, which gives LATCH at done+1 and START at done+2.
  // busy is raised on the edge that asserts act_start and is cleared by
  // act_done in any state, including IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr_latch  <= 1'b0;
      act_start <= 1'b0;
      act_layer <= 3'd0;
      frame_idx <= '0;
      mem_addr  <= '0;
      layer     <= 3'd0;
      sweep     <= '0;
      busy      <= 1'b0;
    end else begin
      sr_latch  <= 1'b0;
      act_start <= 1'b0;

      if (state == LATCH) begin
        busy <= 1'b1;
      end else if (act_done) begin
        busy <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            mem_addr <= calc_addr(frame_idx, layer);
            state    <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD:  state <= SHIFT;
        SHIFT: begin
          if (shift_done) begin
            state <= WAIT_ACT;
          end
        end
        WAIT_ACT: begin
          if (!busy || act_done) begin
            sr_latch <= 1'b1;
            state    <= LATCH;
          end
        end
        LATCH: begin
          act_start <= 1'b1;
          act_layer <= layer;
          state     <= START;
        end
        START: begin
          layer     <= layer_nxt;
          sweep     <= sweep_nxt;
          frame_idx <= frame_nxt;
          mem_addr  <= calc_addr(frame_nxt, layer_nxt);
          state     <= enable ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer with
// NUM_FRAMES = 2 and FRAME_REPEAT = 2. Stimulus pushes the expected word,
// layer, frame and timing of each layer; a negedge monitor pops and compares
// on every sr_latch and act_start. An activator model answers each start
// with act_done after a configurable hold.
module tb_layer_sequencer;
  import cube_pkg::*;

  localparam int NF = 2;
  localparam int FR = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_rdata = '0;
  logic          sr_data;
  logic          sr_clk;
  logic          sr_latch;
  logic          act_start;
  logic [2:0]    act_layer;
  logic          act_done;
  logic [0:0]    frame_idx;

  logic model_done = 1'b0;
  logic spur_done = 1'b0;
  assign act_done = model_done | spur_done;

  logic [63:0] mem [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -100;
  int start_cnt = 0;
  int latch_cnt = 0;
  int hold = 10;

  typedef struct {
    logic [63:0] word;
    logic [2:0]  layer;
    logic [2:0]  prev_layer;
    logic        frame;
    int          exp_cyc;
    bit          rel_done;
  } exp_t;

  exp_t word_q[$];
  exp_t start_q[$];

  layer_sequencer #(
    .NUM_FRAMES  (NF),
    .FRAME_REPEAT(FR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .sr_data  (sr_data),
    .sr_clk   (sr_clk),
    .sr_latch (sr_latch),
    .act_start(act_start),
    .act_layer(act_layer),
    .act_done (act_done),
    .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous frame memory: data one cycle after the address.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic applyStimulus(input logic en_v, output int c0);
    @(posedge clk);
    #1;
    enable = en_v;
    c0 = cyc;
  endtask

  task automatic pushLayer(input int l, input int f, input int prev, input int exp_cyc, input bit rel);
    exp_t e;
    e.word       = mem[f * 8 + l];
    e.layer      = 3'(l);
    e.prev_layer = 3'(prev);
    e.frame      = 1'(f);
    e.exp_cyc    = exp_cyc;
    e.rel_done   = rel;
    word_q.push_back(e);
    start_q.push_back(e);
  endtask

  task automatic waitStarts(input int n, input int budget, input string tag);
    int left;
    left = budget;
    while (start_cnt < n && left > 0) begin
      @(posedge clk);
      #1;
      left--;
    end
    if (start_cnt < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s actual=%0d required=%0d starts", tag, start_cnt, n);
    end
  endtask

  // Activator model: act_done one cycle wide, 'hold' cycles after act_start.
  initial begin
    int h;
    forever begin
      @(negedge clk);
      if (act_start && rst_n) begin
        h = hold;
        repeat (h) @(posedge clk);
        #1;
        model_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk);
        #1;
        model_done = 1'b0;
      end
    end
  end

  // Monitor: rebuilds the shifted word from sr_clk rising edges and checks
  // each latch and start against the scoreboard.
  initial begin
    logic [63:0] shacc;
    int          edges;
    logic        prev_clk;
    exp_t        e;
    shacc = '0;
    edges = 0;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        shacc = '0;
        edges = 0;
        prev_clk = 1'b0;
      end else begin
        if (sr_clk && !prev_clk) begin
          shacc = {shacc[62:0], sr_data};
          edges++;
        end
        prev_clk = sr_clk;
        if (sr_latch) begin
          latch_cnt++;
          checkOutput("sr_clk_in_latch", 64'(sr_clk), 64'd0);
          if (word_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_latch actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = word_q.pop_front();
            checkOutput("shifted_word", shacc, e.word);
            checkOutput("sr_clk_edges", 64'(edges), 64'd64);
            checkOutput("act_layer_held", 64'(act_layer), 64'(e.prev_layer));
            if (e.rel_done) checkOutput("latch_after_done", 64'(cyc), 64'(done_cyc + 1));
          end
          edges = 0;
        end
        if (act_start) begin
          start_cnt++;
          checkOutput("no_latch_with_start", 64'(sr_latch), 64'd0);
          if (start_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_start actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = start_q.pop_front();
            checkOutput("act_layer", 64'(act_layer), 64'(e.layer));
            checkOutput("frame_idx", 64'(frame_idx), 64'(e.frame));
            if (e.exp_cyc != 0) checkOutput("start_cycle", 64'(cyc), 64'(e.exp_cyc));
            if (e.rel_done) checkOutput("start_after_done", 64'(cyc), 64'(done_cyc + 2));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int s_latch;
    int s_start;

    for (int k = 0; k < 16; k++) begin
      mem[k] = {16'hBEEF, 16'(k), 16'h1234, 16'(k * 3 + 1)};
    end
    mem[0] = 64'h0000_0000_0000_00A5;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", 64'(dut.state), 64'(IDLE));
    checkOutput("rst_outputs", {56'd0, sr_data, sr_clk, sr_latch, act_start, act_layer, frame_idx}, 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // First layer exact latency, second layer gated by a long activation,
    // then continuous run through two frames and back to frame 0.
    hold = 300;
    applyStimulus(1'b1, c0);
    for (int i = 0; i < 36; i++) begin
      pushLayer(i % 8, (i / 16) % 2, (i == 0) ? 0 : (i - 1) % 8,
                (i == 0) ? c0 + 133 : 0, (i == 1));
    end
    waitStarts(1, 400, "first");
    hold = 10;
    waitStarts(35, 8000, "run");

    // Drop enable while layer 3 is shifting
    repeat (20) @(posedge clk);
    #1;
    checkOutput("in_shift_l3", 64'(dut.state), 64'(SHIFT));
    enable = 1'b0;
    waitStarts(36, 400, "l3");
    checkOutput("idle_after_l3", 64'(dut.state), 64'(IDLE));
    repeat (300) @(posedge clk);
    #1;
    checkOutput("no_start_idle", 64'(start_cnt), 64'd36);

    // Resume at layer 4 of the same frame
    applyStimulus(1'b1, c0);
    pushLayer(4, 0, 3, c0 + 133, 1'b0);
    waitStarts(37, 400, "resume");

    // Reset while layer 5 is shifting
    repeat (30) @(posedge clk);
    #1;
    checkOutput("in_shift_l5", 64'(dut.state), 64'(SHIFT));
    rst_n = 1'b0;
    enable = 1'b0;
    word_q.delete();
    start_q.delete();
    s_latch = latch_cnt;
    s_start = start_cnt;
    @(posedge clk);
    #1;
    checkOutput("midrst_state", 64'(dut.state), 64'(IDLE));
    checkOutput("midrst_outputs", {56'd0, sr_data, sr_clk, sr_latch, act_start, act_layer, frame_idx}, 64'd0);
    checkOutput("midrst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("midrst_busy", 64'(dut.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst_no_latch", 64'(latch_cnt), 64'(s_latch));
    checkOutput("midrst_no_start", 64'(start_cnt), 64'(s_start));

    // Spurious act_done while not busy must not disturb layer 1 timing
    hold = 10;
    applyStimulus(1'b1, c0);
    pushLayer(0, 0, 0, c0 + 133, 1'b0);
    pushLayer(1, 0, 0, c0 + 266, 1'b0);
    waitStarts(38, 400, "after_rst");
    repeat (40) @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    enable = 1'b0;
    checkOutput("spur_busy", 64'(dut.busy), 64'd0);
    checkOutput("spur_state", 64'(dut.state), 64'(SHIFT));
    waitStarts(39, 400, "spur");
    repeat (20) @(posedge clk);
    #1;
    checkOutput("final_idle", 64'(dut.state), 64'(IDLE));
    checkOutput("scoreboard_empty", 64'(word_q.size() + start_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
